// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
//
// Purpose : Shared definitions for the TDM output scheduler that sits between
//           the per-connector spi_master instances and the LabView parallel
//           output bus.
//
// Contents:
//   state_t      - scheduler FSM state (IDLE, SEND)
//   N_MOD        - number of spi_master modules, also the slots per frame
//   DW           - sample word width
//   DIV          - clocks per output-strobe half period (a slot is 2*DIV)
//   SYNC_CH      - channel index that tags a frame with SYNC
//   IDLE_WORD    - value driven on the data outputs between frames
//   SLOT_W       - slot counter width
//   testpat_word - builds a test-pattern word (only with TDM_TESTPAT_EN)
//
// Configuration macro: TDM_TESTPAT_EN enables the test-pattern helper.
// ---------------------------------------------------------------------------
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int          N_MOD     = 8;
  localparam int          DW        = 10;
  localparam int          DIV       = 5;
  localparam logic [5:0]  SYNC_CH   = 6'd2;
  localparam logic [9:0]  IDLE_WORD = 10'd512;
  localparam int          SLOT_W    = $clog2(N_MOD);

`ifdef TDM_TESTPAT_EN
  // Pattern word {b, slot[2:0], ch}; the caller truncates or zero-extends
  // the result to its own word width.
  function automatic logic [31:0] testpat_word(input logic       b,
                                               input logic [2:0] slot,
                                               input logic [5:0] ch);
    return {22'd0, b, slot, ch};
  endfunction
`endif

endpackage

// File: rtl/tdm_strobe_gen.sv
// ---------------------------------------------------------------------------
// tdm_strobe_gen
//
// Purpose : Slot timing for the TDM output scheduler. Counts 2*DIV clocks per
//           slot, produces the registered output strobe (low for the first
//           DIV clocks of a slot, high for the second DIV clocks) and a
//           combinational slot_adv pulse on the last clock of every slot.
//
// Ports:
//   CLK          in  div_clk, rising edge
//   RST_b        in  synchronous active-low reset
//   start        in  frame start; restarts the divider from zero
//   run          in  high while the scheduler is sending a frame
//   data_out_clk out registered output strobe
//   slot_adv     out high on the last clock of the current slot
// ---------------------------------------------------------------------------
module tdm_strobe_gen
  import tdm_pkg::*;
#(
  parameter int DIV = tdm_pkg::DIV
) (
  input  logic CLK,
  input  logic RST_b,
  input  logic start,
  input  logic run,
  output logic data_out_clk,
  output logic slot_adv
);

  localparam int DIV_W = $clog2(2 * DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV);

  logic [DIV_W-1:0] div;

  assign slot_adv = run && (div == DIV_LAST);

  // The strobe is registered from the divider value, so the first rising
  // edge appears DIV+1 clocks after the frame start edge.
  always_ff @(posedge CLK) begin
    if (!RST_b) begin
      div          <= '0;
      data_out_clk <= 1'b0;
    end else begin
      if (start || !run) begin
        div <= '0;
      end else if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end
      data_out_clk <= run && (div >= DIV_HALF);
    end
  end

endmodule

// File: rtl/tdm_out_sched.sv
// ---------------------------------------------------------------------------
// tdm_out_sched
//
// Purpose : Time-division output scheduler. On each accepted frame_stb it
//           snapshots the A and B words of all N_MOD spi_master modules and
//           then sends them as N_MOD slots of {A,B} pairs, each slot 2*DIV
//           clocks long, with an output strobe, a frame SYNC marker and a
//           sticky overrun flag for frames that arrive while still sending.
//
// Ports:
//   CLK          in  div_clk, rising edge
//   RST_b        in  synchronous active-low reset
//   test_mode    in  capture test pattern instead of live data
//                    (present only with TDM_TESTPAT_EN)
//   en           in  scheduler enable, sampled only when idle
//   frame_stb    in  one-clock pulse, new DATA_A/B valid
//   ch_in        in  channel index of the presented conversion
//   data_a_in    in  flattened DATA_A, module 0 in the LSBs
//   data_b_in    in  flattened DATA_B, module 0 in the LSBs
//   clr_ovr      in  clears the overrun flag
//   data_out_a   out slot A word
//   data_out_b   out slot B word
//   data_out_clk out output strobe, receiver samples on its rising edge
//   sync         out frame marker, high during slot 0 of a tagged frame
//   busy         out high while a frame is being sent
//   overrun      out sticky, a frame was dropped
//   frame_cnt    out frames sent, wraps
//
// Configuration macro: TDM_TESTPAT_EN adds the test_mode input.
// ---------------------------------------------------------------------------
module tdm_out_sched
  import tdm_pkg::*;
#(
  parameter int             N_MOD     = tdm_pkg::N_MOD,
  parameter int             DW        = tdm_pkg::DW,
  parameter int             DIV       = tdm_pkg::DIV,
  parameter logic [5:0]     SYNC_CH   = tdm_pkg::SYNC_CH,
  parameter logic [DW-1:0]  IDLE_WORD = tdm_pkg::IDLE_WORD
) (
  input  logic                CLK,
  input  logic                RST_b,
`ifdef TDM_TESTPAT_EN
  input  logic                test_mode,
`endif
  input  logic                en,
  input  logic                frame_stb,
  input  logic [5:0]          ch_in,
  input  logic [N_MOD*DW-1:0] data_a_in,
  input  logic [N_MOD*DW-1:0] data_b_in,
  input  logic                clr_ovr,
  output logic [DW-1:0]       data_out_a,
  output logic [DW-1:0]       data_out_b,
  output logic                data_out_clk,
  output logic                sync,
  output logic                busy,
  output logic                overrun,
  output logic [15:0]         frame_cnt
);

  localparam int SLOT_BITS = $clog2(N_MOD);

  localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(N_MOD - 1);

  state_t               state;
  logic [SLOT_BITS-1:0] slot;
  logic [DW-1:0]        shadow_a [N_MOD];
  logic [DW-1:0]        shadow_b [N_MOD];
  logic                 sync_tag;

  logic start_frame;
  logic in_send;
  logic slot_adv;
  logic last_slot;
  logic ovr_evt;

  assign in_send     = (state == SEND);
  assign start_frame = (state == IDLE) && frame_stb && en;
  assign last_slot   = slot_adv && (slot == SLOT_LAST);
  // The last clock of a frame still counts as SEND, so a strobe there is
  // dropped rather than accepted.
  assign ovr_evt     = in_send && frame_stb;

  tdm_strobe_gen #(
    .DIV (DIV)
  ) u_strobe (
    .CLK          (CLK),
    .RST_b        (RST_b),
    .start        (start_frame),
    .run          (in_send),
    .data_out_clk (data_out_clk),
    .slot_adv     (slot_adv)
  );

  // Shadow capture decouples the outgoing frame from later spi_master
  // updates; it is written only on an accepted frame start.
  always_ff @(posedge CLK) begin
    if (!RST_b) begin
      sync_tag <= 1'b0;
      for (int i = 0; i < N_MOD; i++) begin
        shadow_a[i] <= IDLE_WORD;
        shadow_b[i] <= IDLE_WORD;
      end
    end else if (start_frame) begin
      sync_tag <= (ch_in == SYNC_CH);
      for (int i = 0; i < N_MOD; i++) begin
`ifdef TDM_TESTPAT_EN
        if (test_mode) begin
          shadow_a[i] <= DW'(testpat_word(1'b0, 3'(i), ch_in));
          shadow_b[i] <= DW'(testpat_word(1'b1, 3'(i), ch_in));
        end else begin
          shadow_a[i] <= data_a_in[i*DW +: DW];
          shadow_b[i] <= data_b_in[i*DW +: DW];
        end
`else
        shadow_a[i] <= data_a_in[i*DW +: DW];
        shadow_b[i] <= data_b_in[i*DW +: DW];
`endif
      end
    end
  end

  // Scheduler FSM. The bus outputs are registered from the current state
  // and slot, so they trail the FSM by one clock: data appears on the edge
  // after the start edge and returns to IDLE_WORD one edge after the FSM
  // has gone back to IDLE, giving exactly N_MOD*2*DIV clocks of data.
  always_ff @(posedge CLK) begin
    if (!RST_b) begin
      state      <= IDLE;
      slot       <= '0;
      data_out_a <= IDLE_WORD;
      data_out_b <= IDLE_WORD;
      sync       <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_frame) begin
            state <= SEND;
            slot  <= '0;
          end
        end
        SEND: begin
          if (slot_adv) begin
            if (last_slot) begin
              state     <= IDLE;
              slot      <= '0;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              slot <= slot + SLOT_BITS'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          slot  <= '0;
        end
      endcase

      busy       <= in_send;
      sync       <= in_send && sync_tag && (slot == '0);
      data_out_a <= in_send ? shadow_a[slot] : IDLE_WORD;
      data_out_b <= in_send ? shadow_b[slot] : IDLE_WORD;

      // A new overrun takes priority over a simultaneous clear.
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_out_sched.sv
// ---------------------------------------------------------------------------
// tb_tdm_out_sched
//
// Purpose : Self-checking bench for tdm_out_sched. A frame-level reference
//           model (clocks elapsed since the capture edge) predicts every
//           output on every clock; a table of fixed probe points checks the
//           first frames against hand-computed values, and directed
//           sequences cover overrun, last-clock strobe, reset mid-frame and
//           the optional test pattern (TDM_TESTPAT_EN).
// ---------------------------------------------------------------------------
module tb_tdm_out_sched;

  localparam int N    = 8;
  localparam int DW   = 10;
  localparam int DIV  = 5;
  localparam int SLOT = 2 * DIV;
  localparam int FL   = N * SLOT;
  localparam logic [9:0] IDLE_W = 10'd512;

  logic          CLK = 1'b0;
  logic          RST_b = 1'b0;
  logic          en = 1'b0;
  logic          frame_stb = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [5:0]    ch_in = 6'd0;
  logic [N*DW-1:0] data_a_in = '0;
  logic [N*DW-1:0] data_b_in = '0;
`ifdef TDM_TESTPAT_EN
  logic          test_mode = 1'b0;
`endif

  logic [DW-1:0] data_out_a;
  logic [DW-1:0] data_out_b;
  logic          data_out_clk;
  logic          sync;
  logic          busy;
  logic          overrun;
  logic [15:0]   frame_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: captured words, tag, and clocks since capture.
  logic [DW-1:0] m_wa [N];
  logic [DW-1:0] m_wb [N];
  bit            m_active = 1'b0;
  int            m_t = 0;
  bit            m_tag = 1'b0;
  logic [15:0]   m_cnt = 16'd0;
  bit            m_ovr = 1'b0;

  int   rise_cnt = 0;
  logic prev_clk = 1'b0;

  typedef struct {
    int         t;
    logic [9:0] a;
    logic [9:0] b;
    logic       clk;
    logic       sync;
    logic       busy;
  } probe_t;

  probe_t probes [12];

  always #5 CLK = ~CLK;

  tdm_out_sched dut (
    .CLK          (CLK),
    .RST_b        (RST_b),
`ifdef TDM_TESTPAT_EN
    .test_mode    (test_mode),
`endif
    .en           (en),
    .frame_stb    (frame_stb),
    .ch_in        (ch_in),
    .data_a_in    (data_a_in),
    .data_b_in    (data_b_in),
    .clr_ovr      (clr_ovr),
    .data_out_a   (data_out_a),
    .data_out_b   (data_out_b),
    .data_out_clk (data_out_clk),
    .sync         (sync),
    .busy         (busy),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt)
  );

  // Frame-level model evaluated once per rising edge with the inputs the
  // DUT sampled on that edge.
  function automatic void model_edge();
    bit in_send;
    if (!RST_b) begin
      m_active = 1'b0;
      m_t      = 0;
      m_cnt    = 16'd0;
      m_ovr    = 1'b0;
    end else begin
      in_send = m_active && (m_t < FL);
      if (in_send && frame_stb) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
      if (m_active) m_t++;
      if (m_active && m_t == FL) m_cnt++;
      if (!in_send && frame_stb && en) begin
        for (int i = 0; i < N; i++) begin
          m_wa[i] = data_a_in[i*DW +: DW];
          m_wb[i] = data_b_in[i*DW +: DW];
`ifdef TDM_TESTPAT_EN
          if (test_mode) begin
            m_wa[i] = DW'((0 << 9) | (i << 6) | int'(ch_in));
            m_wb[i] = DW'((1 << 9) | (i << 6) | int'(ch_in));
          end
`endif
        end
        m_tag    = (ch_in == 6'd2);
        m_active = 1'b1;
        m_t      = 0;
      end else if (m_active && m_t > FL) begin
        m_active = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string name);
    logic [9:0] ea, eb;
    logic       eclk, esync, ebusy;
    int         s;
    ea = IDLE_W; eb = IDLE_W; eclk = 1'b0; esync = 1'b0; ebusy = 1'b0;
    if (m_active && m_t >= 1 && m_t <= FL) begin
      s     = (m_t - 1) / SLOT;
      ea    = m_wa[s];
      eb    = m_wb[s];
      eclk  = ((m_t - 1) % SLOT) >= DIV;
      esync = m_tag && (m_t <= SLOT);
      ebusy = 1'b1;
    end
    tests_run++;
    if ({data_out_a, data_out_b, data_out_clk, sync, busy, overrun, frame_cnt} !==
        {ea, eb, eclk, esync, ebusy, m_ovr, m_cnt}) begin
      tests_failed++;
      $display("[TB] FAIL %s t=%0d: got a=%0d b=%0d clk=%0b sync=%0b busy=%0b ovr=%0b cnt=%0d, expected a=%0d b=%0d clk=%0b sync=%0b busy=%0b ovr=%0b cnt=%0d",
               name, m_t, data_out_a, data_out_b, data_out_clk, sync, busy, overrun, frame_cnt,
               ea, eb, eclk, esync, ebusy, m_ovr, m_cnt);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic stb_v, input logic en_v,
                               input logic clr_v, input logic [5:0] ch_v);
    RST_b     = rst_v;
    frame_stb = stb_v;
    en        = en_v;
    clr_ovr   = clr_v;
    ch_in     = ch_v;
    @(posedge CLK);
    model_edge();
    #1;
    if (data_out_clk && !prev_clk) rise_cnt++;
    prev_clk = data_out_clk;
    checkOutput("cycle");
  endtask

  task automatic set_data(input int off_a, input int off_b);
    for (int i = 0; i < N; i++) begin
      data_a_in[i*DW +: DW] = DW'(10 * i + off_a);
      data_b_in[i*DW +: DW] = DW'(10 * i + off_b);
    end
  endtask

  task automatic scramble_data();
    for (int i = 0; i < N; i++) begin
      data_a_in[i*DW +: DW] = DW'($urandom);
      data_b_in[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic run_idle(input int n, input logic [5:0] ch_v);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, ch_v);
  endtask

  initial begin
    logic [15:0] cnt_before;
    logic [5:0]  chs [2];

    probes[0]  = '{1,  10'd1,  10'd2,  1'b0, 1'b1, 1'b1};
    probes[1]  = '{5,  10'd1,  10'd2,  1'b0, 1'b1, 1'b1};
    probes[2]  = '{6,  10'd1,  10'd2,  1'b1, 1'b1, 1'b1};
    probes[3]  = '{10, 10'd1,  10'd2,  1'b1, 1'b1, 1'b1};
    probes[4]  = '{11, 10'd11, 10'd12, 1'b0, 1'b0, 1'b1};
    probes[5]  = '{16, 10'd11, 10'd12, 1'b1, 1'b0, 1'b1};
    probes[6]  = '{45, 10'd41, 10'd42, 1'b0, 1'b0, 1'b1};
    probes[7]  = '{46, 10'd41, 10'd42, 1'b1, 1'b0, 1'b1};
    probes[8]  = '{71, 10'd71, 10'd72, 1'b0, 1'b0, 1'b1};
    probes[9]  = '{76, 10'd71, 10'd72, 1'b1, 1'b0, 1'b1};
    probes[10] = '{80, 10'd71, 10'd72, 1'b1, 1'b0, 1'b1};
    probes[11] = '{81, 10'd512, 10'd512, 1'b0, 1'b0, 1'b0};
    chs[0] = 6'd2;
    chs[1] = 6'd3;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkVal("reset_outputs", {data_out_a, data_out_b, data_out_clk, sync, busy, overrun},
             {IDLE_W, IDLE_W, 4'b0000});
    checkVal("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    run_idle(3, 6'd0);

    // Tagged and untagged frames checked against the probe table
    for (int f = 0; f < 2; f++) begin
      set_data(1, 2);
      rise_cnt = 0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, chs[f]);
      for (int t = 1; t <= FL + 1; t++) begin
        scramble_data();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, chs[f]);
        for (int p = 0; p < 12; p++) begin
          if (probes[p].t == t) begin
            checkVal($sformatf("probe_ch%0d_t%0d", chs[f], t),
                     {9'd0, data_out_a, data_out_b, data_out_clk, sync, busy},
                     {9'd0, probes[p].a, probes[p].b, probes[p].clk,
                      probes[p].sync && (chs[f] == 6'd2), probes[p].busy});
          end
        end
      end
      checkVal("strobe_rises", 32'(rise_cnt), 32'd8);
      checkVal("frame_cnt_after", 32'(frame_cnt), 32'(f + 1));
    end

    // Overrun: second strobe 40 clocks into a frame
    set_data(1, 2);
    cnt_before = frame_cnt;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd3);
    run_idle(39, 6'd3);
    scramble_data();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd2);
    checkVal("ovr_set_midframe", 32'(overrun), 32'd1);
    run_idle(FL - 40 + 3, 6'd3);
    checkVal("ovr_cnt_plus_one", 32'(frame_cnt), 32'(cnt_before + 16'd1));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
    checkVal("ovr_cleared", 32'(overrun), 32'd0);

    // Strobe on the last clock of a frame is dropped, one clock later accepted
    set_data(1, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd3);
    run_idle(FL - 1, 6'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd3);
    checkVal("last_clk_dropped", 32'(overrun), 32'd1);
    set_data(5, 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd3);
    checkVal("next_clk_idle", {22'd0, data_out_a}, {22'd0, IDLE_W});
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 6'd3);
    checkVal("next_clk_accepted", {21'd0, busy, data_out_a}, {21'd0, 1'b1, 10'd5});
    run_idle(FL + 2, 6'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6'd3);

    // Reset in slot 4, then a fresh frame starts at slot 0
    set_data(1, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd2);
    run_idle(41, 6'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd2);
    checkVal("rst_midframe", {10'd0, data_out_a, data_out_b, data_out_clk, busy},
             {10'd0, IDLE_W, IDLE_W, 2'b00});
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 6'd2);
    checkVal("restart_slot0", {21'd0, sync, data_out_a}, {21'd0, 1'b1, 10'd1});
    run_idle(FL + 2, 6'd2);

    // Strobe with en low is ignored and is not an overrun
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd2);
    checkVal("en_low_ignored", {30'd0, busy, overrun}, 32'd0);

`ifdef TDM_TESTPAT_EN
    // Test pattern: slot 3 with ch_in = 5
    test_mode = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd5);
    test_mode = 1'b0;
    run_idle(31, 6'd5);
    checkVal("testpat_slot3", {12'd0, data_out_a, data_out_b}, {12'd0, 10'h0C5, 10'h2C5});
    run_idle(FL, 6'd5);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      scramble_data();
      applyStimulus(($urandom_range(0, 599) != 0),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 19) == 0),
                    6'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
